exu_wbu: RTL and testbench
==========================

EXU_WBU -- requirements
Module: exu_wbu

Interface
REQ-001 SHALL: parameter XLEN, 32, datapath width; legal values 32 and 64.
REQ-002 SHALL: parameter REG_ADDR_W, 5, GPR index width; 4 for RV32E.
REQ-003 SHALL: parameter MEM_TIMEOUT, 255, maximum cycles spent in WAIT_MEM before abort.
REQ-004 SHALL: localparam OFF_W = log2(XLEN/8), byte-offset width.
REQ-005 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL: in_valid  in  1  EXU presents a write-back request.
REQ-008 SHALL: in_ready  out  1  unit can accept a request.
REQ-009 SHALL: wb_sel  in  2  source select: NONE=0, ALU=1, MEM=2; 3 is reserved and treated as NONE.
REQ-010 SHALL: rd  in  REG_ADDR_W  destination register.
REQ-011 SHALL: alu_result  in  XLEN  ALU write-back value.
REQ-012 SHALL: ld_fmt  in  3  load funct3 (LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110).
REQ-013 SHALL: ld_off  in  OFF_W  low bits of load address.
REQ-014 SHALL: mem_r_valid  in  1  LSU read data valid.
REQ-015 SHALL: mem_r  in  XLEN  LSU aligned read word.
REQ-016 SHALL: gpr_w_en / gpr_w_addr / gpr_w_data  out  1 / REG_ADDR_W / XLEN  registered GPR write port.
REQ-017 SHALL: wb_done  out  1  one-cycle pulse marking request retirement, including aborted requests.
REQ-018 SHALL: err_misalign / err_timeout  out  1 / 1  sticky error flags.

Function
REQ-019 SHALL: FSM states IDLE, WAIT_MEM and WRITE; in_ready=1 only in IDLE.
REQ-020 SHALL: accept when in_valid && in_ready; latch rd, wb_sel, ld_fmt, ld_off and alu_result.
REQ-021 SHALL: on accept, IDLE->WRITE for ALU or NONE, and IDLE->WAIT_MEM for MEM.
REQ-022 SHALL: in WAIT_MEM, sample mem_r_valid only there (mem_r_valid in IDLE/WRITE is ignored); on mem_r_valid latch the formatted data and go to WRITE.
REQ-023 SHALL: in WAIT_MEM, a wait counter, cleared on entry, increments every cycle without mem_r_valid.
REQ-024 SHALL: if the counter reaches MEM_TIMEOUT, set err_timeout, pulse wb_done, perform no write and go to IDLE.
REQ-025 SHALL: WRITE lasts exactly one cycle; gpr_w_en=1 iff wb_sel!=NONE and rd!=0; wb_done=1; next state IDLE.
REQ-026 SHALL: latency — ALU request accepted at cycle N writes at N+1; MEM with mem_r_valid at cycle M writes at M+1; back-to-back ALU throughput is one per 2 cycles.
REQ-027 SHALL: load format — select the byte at ld_off*8, the half at (ld_off>>1)*16, the word at (ld_off>>2)*32; zero-extend for U variants, otherwise sign-extend to XLEN.
REQ-028 SHALL: when XLEN=32, LD/LWU codes are illegal and follow the REQ-031 path.
REQ-029 SHALL: misalignment — half with ld_off[0]=1, word with ld_off[1:0]!=0, or double with ld_off!=0 sets err_misalign at accept, skips WAIT_MEM, goes to WRITE with gpr_w_en=0, and pulses wb_done.
REQ-030 SHALL: gpr_w_addr and gpr_w_data hold their last value when gpr_w_en=0.
REQ-031 SHALL: ld_fmt 111, or an illegal code for the given XLEN, is treated as a full-XLEN load with no extension.

Reset
REQ-032 SHALL: while rst=1 at a clock edge: state=IDLE, counter=0, gpr_w_en=0, gpr_w_addr=0, gpr_w_data=0, wb_done=0, err_misalign=0, err_timeout=0, in_ready=1 on the following cycle.
REQ-033 SHALL: rst asserted mid WAIT_MEM or WRITE drops the pending request with no write and no wb_done.
REQ-034 SHALL: sticky error flags clear only on rst.

Structure
REQ-035 SHALL: shared package exu_wbu_pkg holds the wb_sel encodings, ld_fmt codes and the FSM state enum.
REQ-036 SHALL: combinational sub-module exu_ld_fmt (inputs mem_r, ld_fmt, ld_off; output XLEN data) performs lane select and extension.

Verification
REQ-037 SHALL: ALU request, rd=5, alu_result=0x1234_5678 -> next cycle gpr_w_en=1, gpr_w_addr=5, gpr_w_data=0x1234_5678, wb_done=1.
REQ-038 SHALL: MEM LB, ld_off=3, mem_r=0x80FF_0000 after 3 wait cycles -> gpr_w_data=0xFFFF_FF80 one cycle after mem_r_valid.
REQ-039 SHALL: MEM LHU, ld_off=2, mem_r=0xBEEF_0000 -> gpr_w_data=0x0000_BEEF; the same request with LH -> 0xFFFF_BEEF.
REQ-040 SHALL: ALU request with rd=0 -> gpr_w_en=0, wb_done=1; MEM LW with ld_off=1 -> err_misalign=1, no write, wb_done=1.
REQ-041 SHALL: MEM request with MEM_TIMEOUT=4 and no mem_r_valid -> err_timeout=1, wb_done=1 after 4 wait cycles, in_ready=1 next cycle.
REQ-042 SHALL: rst pulse during WAIT_MEM, then a late mem_r_valid -> no write, all outputs 0, in_ready=1.

Source files
------------

// File: rtl/exu_wbu_pkg.sv
// exu_wbu_pkg: shared encodings and helpers for the write-back unit
package exu_wbu_pkg;
  localparam logic [1:0] WB_NONE = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [2:0] LD_LB = 3'b000;
  localparam logic [2:0] LD_LH = 3'b001;
  localparam logic [2:0] LD_LW = 3'b010;
  localparam logic [2:0] LD_LD = 3'b011;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWU = 3'b110;
  localparam logic [2:0] LD_FULL = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_WRITE} state_t;
  // log2 of the access size in bytes; LD and 111 both collapse to a full-XLEN access
  function automatic logic [1:0] ld_size(input logic [2:0] fmt, input int xlen);
    return fmt[1:0] == 2'b11 ? (xlen == 64 ? 2'd3 : 2'd2) : fmt[1:0];
  endfunction
endpackage

// File: rtl/exu_wbu_if.sv
// exu_wbu_if: EXU request, LSU read data and GPR write port of the write-back unit
interface exu_wbu_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int OFF_W = $clog2(XLEN / 8);
  logic in_valid;
  logic in_ready;
  logic [1:0] wb_sel;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0] alu_result;
  logic [2:0] ld_fmt;
  logic [OFF_W-1:0] ld_off;
  logic mem_r_valid;
  logic [XLEN-1:0] mem_r;
  logic gpr_w_en;
  logic [REG_ADDR_W-1:0] gpr_w_addr;
  logic [XLEN-1:0] gpr_w_data;
  logic wb_done;
  logic err_misalign;
  logic err_timeout;
  modport master (
    output in_valid, wb_sel, rd, alu_result, ld_fmt, ld_off, mem_r_valid, mem_r,
    input in_ready, gpr_w_en, gpr_w_addr, gpr_w_data, wb_done, err_misalign, err_timeout
  );
  modport slave (
    input in_valid, wb_sel, rd, alu_result, ld_fmt, ld_off, mem_r_valid, mem_r,
    output in_ready, gpr_w_en, gpr_w_addr, gpr_w_data, wb_done, err_misalign, err_timeout
  );
endinterface

// File: rtl/exu_ld_fmt.sv
// exu_ld_fmt: selects the load lane from the aligned read word and extends it
module exu_ld_fmt
  import exu_wbu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  mem_r,
  input  logic [2:0]       ld_fmt,
  input  logic [OFF_W-1:0] ld_off,
  output logic [XLEN-1:0]  data
);
  logic [1:0] sz;
  logic [OFF_W-1:0] lane;
  logic [6:0] pad;
  logic sx;
  logic [XLEN-1:0] up;
  logic signed [XLEN-1:0] ext;
  // move the lane to the top, then shift back arithmetically or logically
  always_comb begin
    sz = ld_size(ld_fmt, XLEN);
    lane = (ld_off >> sz) << sz;
    pad = 7'(XLEN - (8 << sz));
    sx = (ld_fmt == LD_LB || ld_fmt == LD_LH || ld_fmt == LD_LW) && pad != '0;
    up = (mem_r >> {lane, 3'b000}) << pad;
    ext = $signed(up) >>> pad;
    data = sx ? ext : up >> pad;
  end
endmodule

// File: rtl/exu_wbu.sv
// exu_wbu: write-back unit retiring ALU results and formatted loads into the GPR file
module exu_wbu
  import exu_wbu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_TIMEOUT = 255,
  localparam int OFF_W = $clog2(XLEN / 8),
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1)
) (
  input logic clk,
  input logic rst,
  exu_wbu_if.slave bus
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [2:0] fmt_q;
  logic [OFF_W-1:0] off_q;
  logic [XLEN-1:0] ld_data;
  logic acc, mis, timeout, abort, alu_wr, mem_wr, w_en_nx, done_nx;
  exu_ld_fmt #(.XLEN(XLEN)) u_ld_fmt (
    .mem_r(bus.mem_r),
    .ld_fmt(fmt_q),
    .ld_off(off_q),
    .data(ld_data)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? S_IDLE : state_nx;
  // next state: misaligned loads bypass the memory wait, valid data beats the timeout
  always_comb begin
    acc = bus.in_valid && state == S_IDLE;
    mis = bus.wb_sel == WB_MEM
      && (bus.ld_off & OFF_W'((1 << ld_size(bus.ld_fmt, XLEN)) - 1)) != '0;
    timeout = cnt == CNT_W'(MEM_TIMEOUT - 1);
    state_nx = state == S_IDLE ? (acc ? (bus.wb_sel == WB_MEM && !mis ? S_WAIT_MEM : S_WRITE) : S_IDLE)
      : state == S_WAIT_MEM ? (bus.mem_r_valid ? S_WRITE : timeout ? S_IDLE : S_WAIT_MEM)
      : S_IDLE;
  end
  // outputs: next values of the registered write port and retirement pulse
  always_comb begin
    bus.in_ready = state == S_IDLE;
    abort = state == S_WAIT_MEM && !bus.mem_r_valid && timeout;
    alu_wr = acc && bus.wb_sel == WB_ALU && bus.rd != '0;
    mem_wr = state == S_WAIT_MEM && bus.mem_r_valid && rd_q != '0;
    w_en_nx = alu_wr || mem_wr;
    done_nx = state_nx == S_WRITE || abort;
  end
  // request latch, wait counter, GPR write port and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rd_q <= '0;
      fmt_q <= '0;
      off_q <= '0;
      bus.gpr_w_en <= 1'b0;
      bus.gpr_w_addr <= '0;
      bus.gpr_w_data <= '0;
      bus.wb_done <= 1'b0;
      bus.err_misalign <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      cnt <= state == S_WAIT_MEM && !bus.mem_r_valid ? cnt + 1'b1 : '0;
      if (acc) begin
        rd_q <= bus.rd;
        fmt_q <= bus.ld_fmt;
        off_q <= bus.ld_off;
      end
      bus.gpr_w_en <= w_en_nx;
      bus.wb_done <= done_nx;
      if (w_en_nx) begin
        bus.gpr_w_addr <= alu_wr ? bus.rd : rd_q;
        bus.gpr_w_data <= alu_wr ? bus.alu_result : ld_data;
      end
      bus.err_misalign <= bus.err_misalign || (acc && mis);
      bus.err_timeout <= bus.err_timeout || abort;
    end
  end
endmodule

// File: tb/tb_exu_wbu.sv
// tb_exu_wbu: randomized transaction bench against a behavioural write-back model
module tb_exu_wbu;
  localparam int XLEN = 32;
  localparam int RW = 5;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [4:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic m_mis = 1'b0;
  logic m_to = 1'b0;
  always #5 clk = ~clk;
  exu_wbu_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
  exu_wbu #(.XLEN(XLEN), .REG_ADDR_W(RW), .MEM_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [1:0] off, input logic [31:0] m);
    int b = int'(off);
    logic [31:0] v;
    case (f)
      3'd0: begin v = (m >> (8 * b)) & 32'hFF; if (v[7]) v = v | 32'hFFFF_FF00; end
      3'd4: v = (m >> (8 * b)) & 32'hFF;
      3'd1: begin v = (m >> (16 * (b / 2))) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
      3'd5: v = (m >> (16 * (b / 2))) & 32'hFFFF;
      default: v = m;
    endcase
    return v;
  endfunction
  function automatic bit ref_mis(input logic [2:0] f, input logic [1:0] off);
    case (f)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return off[0];
      default: return off != 2'd0;
    endcase
  endfunction
  task automatic expect_outs(input string tag, input logic en, input logic done, input logic rdy);
    check({tag, ".w_en"}, 32'(bus.gpr_w_en), 32'(en));
    check({tag, ".done"}, 32'(bus.wb_done), 32'(done));
    check({tag, ".ready"}, 32'(bus.in_ready), 32'(rdy));
    check({tag, ".addr"}, 32'(bus.gpr_w_addr), 32'(m_addr));
    check({tag, ".data"}, bus.gpr_w_data, m_data);
    check({tag, ".mis"}, 32'(bus.err_misalign), 32'(m_mis));
    check({tag, ".to"}, 32'(bus.err_timeout), 32'(m_to));
  endtask
  task automatic alu_req(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val);
    bit wr = sel == 2'd1 && rd != 5'd0;
    check("alu.accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.wb_sel = sel;
    bus.rd = rd;
    bus.alu_result = val;
    bus.ld_fmt = 3'($urandom);
    bus.ld_off = 2'($urandom);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (wr) begin
      m_addr = rd;
      m_data = val;
    end
    expect_outs("alu.write", wr, 1'b1, 1'b0);
    @(negedge clk);
    expect_outs("alu.idle", 1'b0, 1'b0, 1'b1);
  endtask
  task automatic mem_req(input logic [4:0] rd, input logic [2:0] f, input logic [1:0] off,
                         input logic [31:0] m, input int w);
    check("mem.accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.wb_sel = 2'd2;
    bus.rd = rd;
    bus.ld_fmt = f;
    bus.ld_off = off;
    bus.alu_result = $urandom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (ref_mis(f, off)) begin
      m_mis = 1'b1;
      expect_outs("mem.misalign", 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      expect_outs("mem.misalign_idle", 1'b0, 1'b0, 1'b1);
      return;
    end
    for (int i = 0; i <= TO; i++) begin
      if (i == w) begin
        bus.mem_r_valid = 1'b1;
        bus.mem_r = m;
        @(negedge clk);
        bus.mem_r_valid = 1'b0;
        bus.mem_r = $urandom;
        if (rd != 5'd0) begin
          m_addr = rd;
          m_data = ref_load(f, off, m);
        end
        expect_outs("mem.write", rd != 5'd0, 1'b1, 1'b0);
        @(negedge clk);
        expect_outs("mem.idle", 1'b0, 1'b0, 1'b1);
        return;
      end
      expect_outs("mem.wait", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (i + 1 == TO) begin
        m_to = 1'b1;
        expect_outs("mem.timeout", 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        expect_outs("mem.timeout_idle", 1'b0, 1'b0, 1'b1);
        return;
      end
    end
  endtask
  task automatic idle_noise();
    bus.mem_r_valid = 1'b1;
    bus.mem_r = $urandom;
    @(negedge clk);
    bus.mem_r_valid = 1'b0;
    expect_outs("idle_noise", 1'b0, 1'b0, 1'b1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.wb_sel = 2'd0;
    bus.rd = '0;
    bus.alu_result = '0;
    bus.ld_fmt = '0;
    bus.ld_off = '0;
    bus.mem_r_valid = 1'b0;
    bus.mem_r = '0;
    repeat (2) @(negedge clk);
    expect_outs("reset", 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    alu_req(2'd1, 5'd5, 32'h1234_5678);
    alu_req(2'd1, 5'd6, 32'hCAFE_F00D);
    mem_req(5'd7, 3'd0, 2'd3, 32'h80FF_0000, 3);
    check("lb_value", bus.gpr_w_data, 32'hFFFF_FF80);
    mem_req(5'd8, 3'd5, 2'd2, 32'hBEEF_0000, 1);
    check("lhu_value", bus.gpr_w_data, 32'h0000_BEEF);
    mem_req(5'd9, 3'd1, 2'd2, 32'hBEEF_0000, 0);
    check("lh_value", bus.gpr_w_data, 32'hFFFF_BEEF);
    alu_req(2'd1, 5'd0, 32'hDEAD_BEEF);
    alu_req(2'd3, 5'd4, 32'h0BAD_0BAD);
    mem_req(5'd10, 3'd3, 2'd0, 32'h8765_4321, 2);
    mem_req(5'd0, 3'd2, 2'd0, 32'h1111_2222, 0);
    mem_req(5'd10, 3'd2, 2'd1, 32'h5555_AAAA, 0);
    mem_req(5'd11, 3'd2, 2'd0, 32'h7777_7777, TO);
    check("sticky_misalign", 32'(bus.err_misalign), 32'd1);
    bus.in_valid = 1'b1;
    bus.wb_sel = 2'd2;
    bus.rd = 5'd12;
    bus.ld_fmt = 3'd2;
    bus.ld_off = 2'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_mis = 1'b0;
    m_to = 1'b0;
    expect_outs("rst_mid_wait", 1'b0, 1'b0, 1'b1);
    idle_noise();
    expect_outs("rst_late_valid", 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 200; n++) begin
      int k = $urandom_range(0, 2);
      if (k == 0) idle_noise();
      else if (k == 1) begin
        int s = $urandom_range(0, 2);
        alu_req(s == 2 ? 2'd3 : 2'(s), 5'($urandom), $urandom);
      end else mem_req(5'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom_range(0, 5));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
